// File: rtl/hc_stream_dec.sv
// hc_stream_dec: bit-serial Hamming(7,4) receiver.
// Collects 7-bit codewords one bit per cycle (c1 first), corrects any single-bit
// error and presents the 4-bit data word, ordered {c7,c6,c5,c3}, on a valid/ready
// port through a one-entry output register. Flags dropped words (o_ovf, sticky)
// and frames aborted by an early i_sof (o_sync_err, one-cycle pulse).
// Optional feature macro: HC_STREAM_DEC_ERR_CNT_EN enables the saturating
// corrected-word counter on o_err_cnt; when undefined o_err_cnt is tied to 0.

module hc_stream_dec #(
    parameter int unsigned DATA_WD = 4,
    parameter int unsigned CHK_WD  = 3,
    parameter int unsigned CNT_WD  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_bit,
    input  logic               i_bit_vld,
    input  logic               i_sof,
    output logic [DATA_WD-1:0] o_dec_data,
    output logic               o_err_flag,
    output logic [CHK_WD-1:0]  o_err_pos,
    output logic               o_vld,
    input  logic               i_rdy,
    output logic               o_ovf,
    output logic               o_sync_err,
    input  logic               i_clr,
    output logic [CNT_WD-1:0]  o_err_cnt
);

    typedef enum logic {
        StHunt,
        StRecv
    } state_e;

    // Frame assembly state
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:1] cw_q, cw_d;
    logic       sync_err_q, sync_err_d;

    // Completed-word decode
    logic       word_done;
    logic [2:0] bit_pos;
    logic [7:1] word_full;
    logic [7:1] word_fix;
    logic [CHK_WD-1:0]  syndrome;
    logic [DATA_WD-1:0] dec_data;

    // Output register
    logic               vld_q, vld_d;
    logic [DATA_WD-1:0] data_q, data_d;
    logic               flag_q, flag_d;
    logic [CHK_WD-1:0]  pos_q, pos_d;
    logic               ovf_q, ovf_d;
    logic               load;
    logic               drop;

    // Frame FSM: next state, bit count and partial codeword
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cw_d       = cw_q;
        sync_err_d = 1'b0;
        word_done  = 1'b0;
        bit_pos    = cnt_q + 3'd1;

        // Partial word with the incoming bit merged in at position count+1; when the
        // 7th bit arrives this is the complete codeword, decoded in the same cycle.
        word_full = cw_q;
        for (int unsigned k = 1; k <= 7; k++) begin
            if (bit_pos == 3'(k)) begin
                word_full[k] = i_bit;
            end
        end

        if (i_bit_vld) begin
            unique case (state_q)
                StHunt: begin
                    if (i_sof) begin
                        cw_d    = {6'b000000, i_bit};
                        cnt_d   = 3'd1;
                        state_d = StRecv;
                    end
                end
                StRecv: begin
                    if (i_sof) begin
                        // Early start of frame: drop the partial word and restart.
                        sync_err_d = 1'b1;
                        cw_d       = {6'b000000, i_bit};
                        cnt_d      = 3'd1;
                    end else if (cnt_q == 3'd6) begin
                        word_done = 1'b1;
                        cw_d      = word_full;
                        cnt_d     = 3'd0;
                        state_d   = StHunt;
                    end else begin
                        cw_d  = word_full;
                        cnt_d = bit_pos;
                    end
                end
            endcase
        end
    end

    // Frame FSM registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StHunt;
            cnt_q      <= 3'd0;
            cw_q       <= 7'd0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cw_q       <= cw_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Syndrome, single-bit correction and data extraction
    always_comb begin
        syndrome[0] = word_full[1] ^ word_full[3] ^ word_full[5] ^ word_full[7];
        syndrome[1] = word_full[2] ^ word_full[3] ^ word_full[6] ^ word_full[7];
        syndrome[2] = word_full[4] ^ word_full[5] ^ word_full[6] ^ word_full[7];
        word_fix = word_full;
        for (int unsigned k = 1; k <= 7; k++) begin
            if (syndrome == 3'(k)) begin
                word_fix[k] = ~word_full[k];
            end
        end
        dec_data = {word_fix[7], word_fix[6], word_fix[5], word_fix[3]};
    end

    // Output register: load on completion when empty or draining, else drop
    always_comb begin
        load   = word_done && (!vld_q || i_rdy);
        drop   = word_done && vld_q && !i_rdy;
        vld_d  = vld_q;
        data_d = data_q;
        flag_d = flag_q;
        pos_d  = pos_q;
        ovf_d  = ovf_q;

        if (load) begin
            vld_d  = 1'b1;
            data_d = dec_data;
            flag_d = (syndrome != '0);
            pos_d  = syndrome;
        end else if (i_rdy) begin
            vld_d = 1'b0;
        end

        // A drop in the same cycle as i_clr still sets the flag.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Output register state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            flag_q <= 1'b0;
            pos_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            flag_q <= flag_d;
            pos_q  <= pos_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef HC_STREAM_DEC_ERR_CNT_EN
    logic [CNT_WD-1:0] err_cnt_q, err_cnt_d;

    // Corrected-word counter: counts loaded words only, saturates, clear wins
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_clr) begin
            err_cnt_d = '0;
        end else if (load && (syndrome != '0) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Corrected-word counter register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = '0;
`endif

    assign o_dec_data = data_q;
    assign o_err_flag = flag_q;
    assign o_err_pos  = pos_q;
    assign o_vld      = vld_q;
    assign o_ovf      = ovf_q;
    assign o_sync_err = sync_err_q;

endmodule

// File: doc/hc_stream_dec.md
# hc_stream_dec

Bit-serial Hamming(7,4) receiver. It assembles 7-bit codewords arriving one bit per cycle from the serial link, corrects any single-bit error, and presents the 4-bit data word on a valid/ready output port. It is the far-end counterpart of the parallel Hamming(7,4) encoder, using the same bit-position layout. A one-entry output register absorbs downstream stalls; overflow and framing faults are flagged.

## Interface
- DATA_WD, 4, data bits per codeword; only 4 is supported.
- CHK_WD, 3, check bits per codeword; only 3 is supported.
- CNT_WD, 16, width of the corrected-error counter.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_bit  in  1  serial codeword bit.
- i_bit_vld  in  1  i_bit is valid this cycle.
- i_sof  in  1  qualifies i_bit as codeword position 1; ignored unless i_bit_vld is high.
- o_dec_data  out  DATA_WD  corrected data, ordered {c7,c6,c5,c3}.
- o_err_flag  out  1  the held word had a non-zero syndrome.
- o_err_pos  out  3  syndrome {s4,s2,s1}; 0 means no error.
- o_vld  out  1  output word valid.
- i_rdy  in  1  downstream accepts the word.
- o_ovf  out  1  sticky flag: a completed word was dropped.
- o_sync_err  out  1  one-cycle pulse: a frame was aborted by an early i_sof.
- i_clr  in  1  synchronous clear of o_ovf and o_err_cnt.
- o_err_cnt  out  CNT_WD  saturating count of corrected words.

## Operation
- **Codeword layout:** c1=p1, c2=p2, c3=d1, c4=p4, c5=d2, c6=d3, c7=d4. Transmission order is c1 first.
- **Syndrome:**
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s4 = c4^c5^c6^c7
  - A non-zero {s4,s2,s1} inverts bit c[{s4,s2,s1}] before data extraction.
- **FSM states:**
  - HUNT: bits with i_bit_vld high and i_sof low are discarded. i_bit_vld together with i_sof stores c1, sets bit count to 1, and moves to RECV.
  - RECV: each valid bit is stored at position count+1.
  - When the 7th bit is stored, the word is decoded in the same cycle and offered to the output register, then the FSM returns to HUNT.
  - If i_bit_vld and i_sof arrive while in RECV with count 1..6, the partial word is discarded and o_sync_err pulses. The current bit becomes c1 of a new frame and the FSM stays in RECV with count 1.
- **Stalls:** i_bit_vld low holds both state and count.
- **Output register:**
  - Loads when a word completes and either o_vld is low or (o_vld and i_rdy) are both high in the same cycle.
  - If o_vld is high and i_rdy is low when a word completes, the new word is dropped, o_ovf is set, and the held word is unchanged.
  - o_vld clears on a cycle with i_rdy high and no new load.
  - o_dec_data, o_err_flag and o_err_pos are stable while o_vld is high.
- **Clear precedence:** if i_clr and an o_ovf set event occur in the same cycle, the set wins.
- **Reset:** all outputs are 0 after reset, FSM is in HUNT, count is 0. Reset mid-frame discards the partial word.

## Timing
- The 7th bit is sampled at edge N; o_vld is high after edge N, so latency is 1 cycle from the last bit.
- Back-to-back frames: i_sof on the cycle after the 7th bit is accepted without gap.
- Sustained throughput is one word per 7 valid bits. With i_rdy held high, no drop is possible.
- o_sync_err is high for exactly the cycle after the aborting i_sof edge.
- o_ovf is high from the edge after the drop until i_clr or i_rst.

## Configuration
- Macro: HC_STREAM_DEC_ERR_CNT_EN.
- **Defined:** o_err_cnt increments by 1 on each output-register load with a non-zero syndrome. Dropped words are not counted. The counter saturates at all ones. i_clr zeroes it; if i_clr and an increment occur in the same cycle, the result is 0.
- **Undefined:** the counter logic is removed and o_err_cnt is tied to 0.

## Test plan
- **Clean word:** i_data 4'b1011 sent as c1..c7 = 1,0,1,0,1,0,1 with i_sof on the first bit and i_rdy=1. Expect o_vld 1 cycle after the 7th bit, o_dec_data=4'b1011, o_err_flag=0, o_err_pos=0.
- **Single-bit error:** same word with c5 flipped (1,0,1,0,0,0,1). Expect o_dec_data=4'b1011, o_err_flag=1, o_err_pos=3'd5, and o_err_cnt=1 with the macro defined.
- **Framing:** i_sof asserted again at bit 4. Expect an o_sync_err pulse and, after 7 more bits from the new i_sof, one correct word.
- **Backpressure:** i_rdy=0 across two complete words. Expect the first word held, the second dropped, and o_ovf=1. Then i_clr pulse gives o_ovf=0, and i_rdy=1 consumes the first word.
- **Stalls:** i_bit_vld deasserted for 3 cycles between bits 3 and 4. Expect a correct decode with latency measured from the 7th valid bit; also check that a valid bit in HUNT without i_sof produces no output.
- **Reset:** assert i_rst after bit 5 of a frame. Expect all outputs 0; a following complete frame decodes correctly.
